// File: rtl/sig_unpacker.sv
// -----------------------------------------------------------------------------
// sig_unpacker
// Front end of the SM4-Picnic signature verifier. A serialized signature
// arrives as a 32-bit word stream: one header word followed by BODY_WORDS
// body words. Body words are shifted into one wide field register, so the
// first body word lands in the MSBs. The header and the stream length are
// checked, and the decoded fields are presented in parallel until the
// downstream stage acknowledges them.
//
// Optional build macro: SIG_WORD_SWAP_EN
//   defined   - every incoming word (header included) is byte-reversed,
//               so a little-endian serialized stream is accepted
//   undefined - words are used exactly as received
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   unpack_start        level; begins one unpack while idle
//   s_data/s_valid/s_last/s_ready  input word stream (valid/ready)
//   t                   header bits [31:24]
//   Ht .. aux_triangle  decoded signature fields, MSB-first slices
//   out_valid           fields and unpack_err are stable
//   unpack_err          stream was malformed
//   out_ack             downstream has consumed the result
// -----------------------------------------------------------------------------
module sig_unpacker #(
    parameter int          BODY_WORDS = 612,
    parameter logic [23:0] MAGIC      = 24'h534D34,
    parameter int          T_MAX      = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           unpack_start,
    input  logic [31:0]    s_data,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [7:0]     t,
    output logic [255:0]   Ht,
    output logic [255:0]   salt,
    output logic [511:0]   seed_star,
    output logic [1023:0]  Cv,
    output logic [127:0]   seed_triangle,
    output logic [7679:0]  seedInfo,
    output logic [511:0]   masked_key,
    output logic [2047:0]  msgs,
    output logic [1023:0]  C,
    output logic [2047:0]  seed_lambda,
    output logic [4095:0]  aux_triangle,
    output logic           out_valid,
    output logic           unpack_err,
    input  logic           out_ack
);

    localparam int SREG_W = BODY_WORDS * 32;

    // LSB position of each field inside the field register, built up from
    // the bottom (aux_triangle) to the top (Ht).
    localparam int P_AUX  = 0;
    localparam int P_SL   = P_AUX  + 4096;
    localparam int P_C    = P_SL   + 2048;
    localparam int P_MSGS = P_C    + 1024;
    localparam int P_MK   = P_MSGS + 2048;
    localparam int P_SI   = P_MK   + 512;
    localparam int P_ST   = P_SI   + 7680;
    localparam int P_CV   = P_ST   + 128;
    localparam int P_SS   = P_CV   + 1024;
    localparam int P_SALT = P_SS   + 512;
    localparam int P_HT   = P_SALT + 256;

    localparam logic [9:0] LAST_IDX = 10'(BODY_WORDS - 1);
    localparam logic [7:0] T_LIMIT  = 8'(T_MAX);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        DRAIN,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [9:0]          cnt_reg, cnt_next;
    logic [7:0]          t_reg, t_next;
    logic                err_reg, err_next;
    logic [SREG_W-1:0]   sreg_reg;
    logic                shift_en;
    logic [31:0]         data;
    logic                hdr_bad;

`ifdef SIG_WORD_SWAP_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_swap
        assign data[8*gi +: 8] = s_data[8*(3-gi) +: 8];
    end
`else
    assign data = s_data;
`endif

    assign hdr_bad = (data[23:0] != MAGIC) || (data[31:24] == 8'd0) ||
                     (data[31:24] > T_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            t_reg     <= '0;
            err_reg   <= 1'b0;
            sreg_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            t_reg     <= t_next;
            err_reg   <= err_next;
            if (shift_en) begin
                sreg_reg <= {sreg_reg[SREG_W-33:0], data};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        t_next     = t_reg;
        err_next   = err_reg;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                // out_valid is always low here, so the start level is enough
                if (unpack_start) begin
                    state_next = HDR;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                end
            end
            HDR: begin
                if (s_valid) begin
                    t_next = data[31:24];
                    if (hdr_bad) begin
                        err_next   = 1'b1;
                        state_next = s_last ? DONE : DRAIN;
                    end else if (s_last) begin
                        // header with no body
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BODY;
                    end
                end
            end
            BODY: begin
                if (s_valid) begin
                    shift_en = 1'b1;
                    cnt_next = cnt_reg + 10'd1;
                    if (cnt_reg == LAST_IDX) begin
                        if (s_last) begin
                            state_next = DONE;
                        end else begin
                            // too many words: keep the good prefix, drop the rest
                            err_next   = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (s_last) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_ready    = (state_reg == HDR) || (state_reg == BODY) ||
                        (state_reg == DRAIN);
    assign out_valid  = (state_reg == DONE);
    assign unpack_err = err_reg;
    assign t          = t_reg;

    assign Ht            = sreg_reg[P_HT   +: 256];
    assign salt          = sreg_reg[P_SALT +: 256];
    assign seed_star     = sreg_reg[P_SS   +: 512];
    assign Cv            = sreg_reg[P_CV   +: 1024];
    assign seed_triangle = sreg_reg[P_ST   +: 128];
    assign seedInfo      = sreg_reg[P_SI   +: 7680];
    assign masked_key    = sreg_reg[P_MK   +: 512];
    assign msgs          = sreg_reg[P_MSGS +: 2048];
    assign C             = sreg_reg[P_C    +: 1024];
    assign seed_lambda   = sreg_reg[P_SL   +: 2048];
    assign aux_triangle  = sreg_reg[P_AUX  +: 4096];

endmodule

// File: tb/tb_sig_unpacker.sv
// -----------------------------------------------------------------------------
// tb_sig_unpacker
// Directed bench for sig_unpacker: good stream, bad headers, header-only,
// short and long streams, stalled stream with a mid-stream reset. Expected
// field contents come from a reference image of the body words built here.
// -----------------------------------------------------------------------------
module tb_sig_unpacker;

    localparam int BW  = 612;
    localparam int SW  = BW * 32;
    localparam logic [31:0] GOOD_HDR = 32'h08534D34;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           unpack_start = 1'b0;
    logic [31:0]    s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           out_ack = 1'b0;
    logic           s_ready;
    logic [7:0]     t;
    logic [255:0]   Ht;
    logic [255:0]   salt;
    logic [511:0]   seed_star;
    logic [1023:0]  Cv;
    logic [127:0]   seed_triangle;
    logic [7679:0]  seedInfo;
    logic [511:0]   masked_key;
    logic [2047:0]  msgs;
    logic [1023:0]  C;
    logic [2047:0]  seed_lambda;
    logic [4095:0]  aux_triangle;
    logic           out_valid;
    logic           unpack_err;

    int             n_checks = 0;
    int             n_fail = 0;
    int             ready_bad = 0;
    logic [SW-1:0]  exp_sreg;

    sig_unpacker dut (
        .clk           (clk),
        .reset         (reset),
        .unpack_start  (unpack_start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .t             (t),
        .Ht            (Ht),
        .salt          (salt),
        .seed_star     (seed_star),
        .Cv            (Cv),
        .seed_triangle (seed_triangle),
        .seedInfo      (seedInfo),
        .masked_key    (masked_key),
        .msgs          (msgs),
        .C             (C),
        .seed_lambda   (seed_lambda),
        .aux_triangle  (aux_triangle),
        .out_valid     (out_valid),
        .unpack_err    (unpack_err),
        .out_ack       (out_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7679:0] obs,
                       input logic [7679:0] exp);
        int w;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            w = 0;
            for (int i = 0; i < 240; i++) begin
                if (obs[32*i +: 32] !== exp[32*i +: 32]) begin
                    w = i;
                    break;
                end
            end
            $error("FAIL %s: observed word[%0d]=%h expected %h", tag, w,
                   obs[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    function automatic logic [31:0] enc(input logic [31:0] w);
`ifdef SIG_WORD_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] word_of(input int i, input int pat);
        logic [31:0] v;
        v = 32'(i);
        if (pat != 0) v = v * 32'h9E3779B9 + 32'h1;
        return v;
    endfunction

    task automatic build_exp(input int pat);
        for (int i = 0; i < BW; i++) exp_sreg[SW-1-32*i -: 32] = word_of(i, pat);
    endtask

    // One word on the stream; an optional idle cycle is inserted before it.
    task automatic send(input logic [31:0] w, input logic last, input bit gap);
        if (gap && ($urandom_range(0, 1) == 1)) begin
            @(posedge clk); #1;
        end
        s_data  = enc(w);
        s_valid = 1'b1;
        s_last  = last;
        if (s_ready !== 1'b1) ready_bad++;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic do_start();
        unpack_start = 1'b1;
        @(posedge clk); #1;
        unpack_start = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
    endtask

    task automatic check_fields(input string p);
        chk({p, "_Ht"},   Ht,            exp_sreg[19328 +: 256]);
        chk({p, "_salt"}, salt,          exp_sreg[19072 +: 256]);
        chk({p, "_ss"},   seed_star,     exp_sreg[18560 +: 512]);
        chk({p, "_Cv"},   Cv,            exp_sreg[17536 +: 1024]);
        chk({p, "_st"},   seed_triangle, exp_sreg[17408 +: 128]);
        chk({p, "_si"},   seedInfo,      exp_sreg[9728 +: 7680]);
        chk({p, "_mk"},   masked_key,    exp_sreg[9216 +: 512]);
        chk({p, "_msgs"}, msgs,          exp_sreg[7168 +: 2048]);
        chk({p, "_C"},    C,             exp_sreg[6144 +: 1024]);
        chk({p, "_sl"},   seed_lambda,   exp_sreg[4096 +: 2048]);
        chk({p, "_aux"},  aux_triangle,  exp_sreg[0 +: 4096]);
    endtask

    initial begin
        logic [31:0] bad_hdr [3];
        logic [7:0]  bad_t [3];
        int          hi;

        bad_hdr[0] = 32'h08000000; bad_t[0] = 8'd8;
        bad_hdr[1] = 32'h00534D34; bad_t[1] = 8'd0;
        bad_hdr[2] = 32'h11534D34; bad_t[2] = 8'd17;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", unpack_err, 0);
        chk("rst_t", t, 0);
        chk("rst_Ht", Ht, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ---- good stream ----
        do_start();
        ready_bad = 0;
        send(GOOD_HDR, 1'b0, 1'b0);
        for (int i = 0; i < BW; i++) send(word_of(i, 0), i == BW - 1, 1'b0);
        chk("good_out_valid", out_valid, 1);
        chk("good_err", unpack_err, 0);
        chk("good_t", t, 8);
        chk("good_ready", ready_bad, 0);
        chk("good_Ht_top", Ht[255:224], 0);
        chk("good_aux_low", aux_triangle[31:0], 611);
        build_exp(0);
        check_fields("good");
        // out_ack goes high 5 cycles after out_valid; 6 valid cycles expected
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid === 1'b1) hi++;
            if (k == 5) out_ack = 1'b1;
            @(posedge clk); #1;
        end
        out_ack = 1'b0;
        chk("good_valid_cycles", hi, 6);
        chk("good_idle_valid", out_valid, 0);
        chk("good_idle_ready", s_ready, 0);

        // ---- bad headers: bad magic, t=0, t=17 ----
        for (int k = 0; k < 3; k++) begin
            do_start();
            ready_bad = 0;
            send(bad_hdr[k], 1'b0, 1'b0);
            send(32'h1, 1'b0, 1'b0);
            send(32'h2, 1'b0, 1'b0);
            send(32'h3, 1'b1, 1'b0);
            chk($sformatf("badhdr%0d_valid", k), out_valid, 1);
            chk($sformatf("badhdr%0d_err", k), unpack_err, 1);
            chk($sformatf("badhdr%0d_t", k), t, bad_t[k]);
            chk($sformatf("badhdr%0d_ready", k), ready_bad, 0);
            chk($sformatf("badhdr%0d_Ht_kept", k), Ht, exp_sreg[19328 +: 256]);
            if (k < 2) do_ack();
        end
        // start is ignored in DONE; a held level restarts right after ack
        unpack_start = 1'b1;
        @(posedge clk); #1;
        chk("start_ignored_done", out_valid, 1);
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        chk("after_ack_idle", s_ready, 0);
        @(posedge clk); #1;
        unpack_start = 1'b0;
        chk("held_start_hdr", s_ready, 1);

        // ---- header-only stream ----
        send(GOOD_HDR, 1'b1, 1'b0);
        chk("hdronly_valid", out_valid, 1);
        chk("hdronly_err", unpack_err, 1);
        do_ack();

        // ---- short stream: s_last on body word 100 ----
        do_start();
        send(GOOD_HDR, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) send(32'(i + 1000), 1'b0, 1'b0);
        chk("short_not_done", out_valid, 0);
        send(32'd1100, 1'b1, 1'b0);
        chk("short_valid", out_valid, 1);
        chk("short_err", unpack_err, 1);
        do_ack();

        // ---- long stream: 615 body words ----
        do_start();
        ready_bad = 0;
        send(GOOD_HDR, 1'b0, 1'b0);
        for (int i = 0; i < BW + 3; i++) send(word_of(i, 0), i == BW + 2, 1'b0);
        chk("long_valid", out_valid, 1);
        chk("long_err", unpack_err, 1);
        chk("long_ready", ready_bad, 0);
        chk("long_aux_low", aux_triangle[31:0], 611);
        chk("long_aux", aux_triangle, exp_sreg[0 +: 4096]);
        chk("long_Ht", Ht, exp_sreg[19328 +: 256]);
        do_ack();
        chk("long_err_held", unpack_err, 1);
        chk("long_idle_valid", out_valid, 0);

        // ---- stalled stream aborted by reset at body word 300 ----
        do_start();
        chk("restart_clears_err", unpack_err, 0);
        send(GOOD_HDR, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) send(word_of(i, 1), 1'b0, 1'b1);
        reset = 1'b0;
        #2;
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_t", t, 0);
        chk("midrst_Ht", Ht, 0);
        chk("midrst_aux", aux_triangle, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", s_ready, 0);

        // ---- fresh stalled stream after reset ----
        do_start();
        ready_bad = 0;
        send(GOOD_HDR, 1'b0, 1'b1);
        for (int i = 0; i < BW; i++) send(word_of(i, 1), i == BW - 1, 1'b1);
        chk("gap_valid", out_valid, 1);
        chk("gap_err", unpack_err, 0);
        chk("gap_t", t, 8);
        chk("gap_ready", ready_bad, 0);
        build_exp(1);
        check_fields("gap");
        do_ack();
        chk("gap_idle_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
